// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment (FND) scan engine.
//   SEG_0..SEG_9 : active-low segment fonts, bit7 = dp (dp bit left high here)
//   FONT_BLANK   : all segments off
//   DP_MASK      : AND mask that turns the decimal point on
//   fnd_cfg_ok() : legality check for the slot divider / brightness resolution
package fnd_pkg;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [7:0] FONT_BLANK = 8'hFF;
  localparam logic [7:0] DP_MASK    = 8'h7F;

  // A slot must split evenly into 2**bright_bits PWM phases of at least one clock.
  function automatic bit fnd_cfg_ok(input int unsigned div, input int unsigned bright_bits);
    if (bright_bits < 1 || bright_bits > 8) return 1'b0;
    if (div < 2) return 1'b0;
    if ((div >> bright_bits) < 1) return 1'b0;
    return (div % (32'd1 << bright_bits)) == 0;
  endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational BCD-to-7-segment font decoder (active low, dp left off).
//   code   : 4-bit digit code; values above 9 decode to a blank font
//   font_c : 8-bit active-low segment pattern, bit7 (dp) always 1
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] font_c
);

  always_comb begin
    font_c = FONT_BLANK;
    case (code)
      4'd0:    font_c = SEG_0;
      4'd1:    font_c = SEG_1;
      4'd2:    font_c = SEG_2;
      4'd3:    font_c = SEG_3;
      4'd4:    font_c = SEG_4;
      4'd5:    font_c = SEG_5;
      4'd6:    font_c = SEG_6;
      4'd7:    font_c = SEG_7;
      4'd8:    font_c = SEG_8;
      4'd9:    font_c = SEG_9;
      default: font_c = FONT_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_engine.sv
// N-digit multiplexed 7-segment scan driver with frame snapshot, leading-zero
// blanking, PWM brightness and hardware blink.
//   clk, reset   : system clock, asynchronous active-high reset
//   digits       : packed BCD codes, digit i at [4i+3:4i], digit 0 rightmost
//   dot_mask     : per-digit decimal point enable
//   blink_mask   : per-digit blink enable
//   lzb_en       : blank leading zeros (digit 0 always shown)
//   brightness   : PWM level, 0 = dark, all-ones = full on
//   fnd_font     : active-low segments, bit7 = dp (registered)
//   fnd_comm     : active-low digit enables, at most one low (registered)
//   frame_start  : one-clock pulse in the cycle the slot index wraps to 0
module fnd_scan_engine
  import fnd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned BRIGHT_BITS = 3,
  parameter int unsigned BLINK_HALF  = 50_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dot_mask,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      lzb_en,
  input  logic [BRIGHT_BITS-1:0]    brightness,
  output logic [7:0]                fnd_font,
  output logic [NUM_DIGITS-1:0]     fnd_comm,
  output logic                      frame_start
);

  localparam int unsigned DIV       = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLK_W     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int unsigned PHASE_DIV = DIV >> BRIGHT_BITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  // Reject configurations that cannot be scanned correctly.
  if (!fnd_cfg_ok(DIV, BRIGHT_BITS) || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_cfg_bad
    $error("fnd_scan_engine: illegal NUM_DIGITS/DIV/BRIGHT_BITS combination");
  end

  // Slot timing and scan position
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             tick_c;
  logic             wrap_c;
  logic             frame_start_nxt;

  // Blink timer
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // Frame snapshot
  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dot;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic                    snap_lzb;
  logic [BRIGHT_BITS-1:0]  snap_bright;

  // Current-slot decode
  logic [3:0]             code_c;
  logic [7:0]             seg_c;
  logic                   dot_c;
  logic                   blink_c;
  logic                   lzb_blank_c;
  logic [NUM_DIGITS-1:0]  lzb_blank_vec;
  logic                   zero_run;
  logic [BRIGHT_BITS-1:0] phase_c;
  logic                   pwm_on_c;
  logic                   lit_c;
  logic [7:0]             font_nxt;
  logic [NUM_DIGITS-1:0]  comm_nxt;

  // Slot counter and digit index; frame_start is registered one cycle early so it
  // is high in exactly the cycle where the index wraps.
  always_comb begin
    tick_c    = (count == CNT_LAST);
    wrap_c    = tick_c && (idx == IDX_LAST);
    count_nxt = tick_c ? '0 : count + CNT_W'(1);
    idx_nxt   = idx;
    if (tick_c) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
    frame_start_nxt = (count_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
  end

  // Leading-zero run from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    zero_run      = snap_lzb;
    lzb_blank_vec = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      zero_run         = zero_run & (snap_digits[4*i +: 4] == 4'd0);
      lzb_blank_vec[i] = zero_run;
    end
  end

  // Per-digit attributes of the slot being scanned.
  always_comb begin
    code_c      = '0;
    dot_c       = 1'b0;
    blink_c     = 1'b0;
    lzb_blank_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        code_c      = snap_digits[4*i +: 4];
        dot_c       = snap_dot[i];
        blink_c     = snap_blink[i];
        lzb_blank_c = lzb_blank_vec[i];
      end
    end
  end

  fnd_seg_decode u_seg_decode (
    .code   (code_c),
    .font_c (seg_c)
  );

  // Lit decision; count 0 of every slot is the anti-ghosting gap.
  always_comb begin
    phase_c  = BRIGHT_BITS'(count / CNT_W'(PHASE_DIV));
    pwm_on_c = (&snap_bright) || (phase_c < snap_bright);
    lit_c    = (count != '0) && pwm_on_c && !(blink_c && blink_phase) && !lzb_blank_c;
    font_nxt = lit_c ? (seg_c & (dot_c ? DP_MASK : FONT_BLANK)) : FONT_BLANK;
    comm_nxt = lit_c ? ~(NUM_DIGITS'(1) << idx) : '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_digits <= '0;
      snap_dot    <= '0;
      snap_blink  <= '0;
      snap_lzb    <= 1'b0;
      snap_bright <= '0;
      fnd_font    <= FONT_BLANK;
      fnd_comm    <= '1;
      frame_start <= 1'b0;
    end else begin
      count       <= count_nxt;
      idx         <= idx_nxt;
      frame_start <= frame_start_nxt;

      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end

      if (wrap_c) begin
        snap_digits <= digits;
        snap_dot    <= dot_mask;
        snap_blink  <= blink_mask;
        snap_lzb    <= lzb_en;
        snap_bright <= brightness;
      end

      fnd_font <= font_nxt;
      fnd_comm <= comm_nxt;
    end
  end

endmodule

// File: tb/tb_fnd_scan_engine.sv
// Self-checking bench for fnd_scan_engine (4 digits, 16 clocks/slot, 2-bit brightness).
module tb_fnd_scan_engine;

  localparam int N     = 4;
  localparam int DIV   = 16;
  localparam int BH    = 128;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  dot_mask = 4'b0000;
  logic [3:0]  blink_mask = 4'b0000;
  logic        lzb_en = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic [7:0]  fnd_font;
  logic [3:0]  fnd_comm;
  logic        frame_start;

  fnd_scan_engine #(
    .NUM_DIGITS  (4),
    .CLK_HZ      (64),
    .SCAN_HZ     (4),
    .BRIGHT_BITS (2),
    .BLINK_HALF  (128)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .dot_mask    (dot_mask),
    .blink_mask  (blink_mask),
    .lzb_en      (lzb_en),
    .brightness  (brightness),
    .fnd_font    (fnd_font),
    .fnd_comm    (fnd_comm),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: k = clock edges since reset release; s_* = frame snapshot.
  int          k = 0;
  logic [15:0] s_dig = '0;
  logic [3:0]  s_dot = '0;
  logic [3:0]  s_blk = '0;
  logic        s_lzb = 1'b0;
  logic [1:0]  s_br = '0;
  logic [3:0]  exp_comm = 4'hF;
  logic [7:0]  exp_font = 8'hFF;
  logic        exp_fs = 1'b0;

  logic [7:0] seg_rom [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [7:0] seg_of(input logic [3:0] c);
    if (c > 4'd9) return 8'hFF;
    return seg_rom[c];
  endfunction

  // What is shown while the engine sits kk clocks after reset.
  function automatic bit model_lit(input int kk);
    int cnt   = kk % DIV;
    int di    = (kk / DIV) % N;
    int ph    = cnt / (DIV / 4);
    bit blink = ((kk / BH) % 2) == 1;
    bit pwm   = (s_br == 2'd3) || (ph < int'(s_br));
    bit lzb   = s_lzb && (di != 0) && ((s_dig >> (4 * di)) == 16'd0);
    return (cnt != 0) && pwm && !(s_blk[di] && blink) && !lzb;
  endfunction

  function automatic logic [3:0] model_comm(input int kk);
    int di = (kk / DIV) % N;
    if (!model_lit(kk)) return 4'hF;
    return ~(4'b0001 << di);
  endfunction

  function automatic logic [7:0] model_font(input int kk);
    int di = (kk / DIV) % N;
    logic [3:0] code = s_dig[4*di +: 4];
    if (!model_lit(kk)) return 8'hFF;
    return seg_of(code) & (s_dot[di] ? 8'h7F : 8'hFF);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      k        <= 0;
      s_dig    <= '0;
      s_dot    <= '0;
      s_blk    <= '0;
      s_lzb    <= 1'b0;
      s_br     <= '0;
      exp_comm <= 4'hF;
      exp_font <= 8'hFF;
      exp_fs   <= 1'b0;
    end else begin
      exp_comm <= model_comm(k);
      exp_font <= model_font(k);
      exp_fs   <= ((k + 1) % FRAME) == FRAME - 1;
      if ((k % FRAME) == FRAME - 1) begin
        s_dig <= digits;
        s_dot <= dot_mask;
        s_blk <= blink_mask;
        s_lzb <= lzb_en;
        s_br  <= brightness;
      end
      k <= k + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (k=%0d, t=%0t)", name, got, want, k, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    chk("comm", 32'(fnd_comm), 32'(exp_comm));
    chk("font", 32'(fnd_font), 32'(exp_font));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
  end

  task automatic go_to(input int e);
    int guard = 0;
    while (k < e && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (k != e) chk("go_to_timeout", 32'(k), 32'(e));
  endtask

  task automatic pin(input string name, input int e, input logic [3:0] comm, input logic [7:0] font);
    go_to(e);
    chk({name, "_comm"}, 32'(fnd_comm), 32'(comm));
    chk({name, "_font"}, 32'(fnd_font), 32'(font));
  endtask

  task automatic rand_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N; i++)
          digits[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) dot_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) lzb_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) brightness = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and the dark first frame (snapshot still cleared).
    pin("rst_out", 1, 4'hF, 8'hFF);
    pin("frame0_dark", 20, 4'hF, 8'hFF);
    go_to(62); chk("fs_before", 32'(frame_start), 32'd0);
    go_to(63); chk("fs_first", 32'(frame_start), 32'd1);

    // 1234 at full brightness.
    pin("d0", 66, 4'b1110, 8'h99);
    pin("gap", 81, 4'b1111, 8'hFF);
    pin("d1", 82, 4'b1101, 8'hB0);
    pin("d2", 98, 4'b1011, 8'hA4);
    pin("d3", 114, 4'b0111, 8'hF9);

    // Mid-frame change is deferred to the next frame.
    digits = 16'h5678;
    pin("no_tear", 120, 4'b0111, 8'hF9);
    pin("new_d0", 130, 4'b1110, 8'h80);
    pin("new_d1", 146, 4'b1101, 8'hF8);

    // Leading-zero blanking.
    digits = 16'h0050;
    lzb_en = 1'b1;
    pin("lzb_d0", 194, 4'b1110, 8'hC0);
    pin("lzb_d1", 210, 4'b1101, 8'h92);
    pin("lzb_d2", 226, 4'b1111, 8'hFF);
    pin("lzb_d3", 242, 4'b1111, 8'hFF);

    // Quarter duty: lit on slot clocks 1..3 only.
    brightness = 2'd1;
    pin("pwm_c1", 258, 4'b1110, 8'hC0);
    pin("pwm_c3", 260, 4'b1110, 8'hC0);
    pin("pwm_c4", 261, 4'b1111, 8'hFF);
    pin("pwm_d1", 276, 4'b1101, 8'h92);
    pin("pwm_off", 277, 4'b1111, 8'hFF);

    // Brightness 0 is dark.
    brightness = 2'd0;
    pin("dark", 322, 4'b1111, 8'hFF);

    // Blink on digit 0, dot on digit 2.
    digits     = 16'h1234;
    brightness = 2'd3;
    lzb_en     = 1'b0;
    blink_mask = 4'b0001;
    dot_mask   = 4'b0100;
    pin("blink_off", 386, 4'b1111, 8'hFF);
    pin("dot_d2", 418, 4'b1011, 8'h24);
    pin("blink_on", 514, 4'b1110, 8'h99);

    rand_phase(3000);

    // Asynchronous reset mid-slot blanks outputs without a clock edge.
    digits     = 16'h1234;
    brightness = 2'd3;
    blink_mask = 4'b0000;
    dot_mask   = 4'b0000;
    lzb_en     = 1'b0;
    go_to(k + 140);
    while ((k % DIV) != 5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_comm", 32'(fnd_comm), 32'hF);
    chk("async_font", 32'(fnd_font), 32'hFF);
    chk("async_fs", 32'(frame_start), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    go_to(62); chk("rst_fs_before", 32'(frame_start), 32'd0);
    go_to(63); chk("rst_fs_first", 32'(frame_start), 32'd1);
    pin("rst_d0", 66, 4'b1110, 8'h99);

    rand_phase(2000);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
